// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB register: word/half/byte loads and stores over a variable-latency data-memory handshake.
// Latency: 1 cycle for non-memory ops, 2+ cycles for memory ops; upstream is stalled while an access is outstanding.
module mem_wb_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Valid_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  MemSize_in,
    input  logic        MemSigned_in,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] ReadData2_in,
    input  logic [4:0]  WriteReg_in,
    output logic        Stall_out,
    output logic        Dmem_Req,
    output logic        Dmem_We,
    output logic [31:0] Dmem_Addr,
    output logic [31:0] Dmem_WData,
    output logic [3:0]  Dmem_BE,
    input  logic [31:0] Dmem_RData,
    input  logic        Dmem_Ready,
    output logic        Valid_out,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] ALUResult_out,
    output logic [4:0]  WriteReg_out,
    output logic        AlignErr_out,
    output logic        BusErr_out
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  cnt;

    logic [1:0]  lat_size;
    logic        lat_signed;
    logic        lat_we;
    logic        lat_regwrite;
    logic        lat_memtoreg;
    logic [31:0] lat_addr;
    logic [4:0]  lat_wreg;

    logic        memop;
    logic        is_half;
    logic        is_byte;
    logic        misaligned;
    logic        issue;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign memop      = Valid_in & (MemRead_in | MemWrite_in);
    assign is_half    = (MemSize_in == 2'b01);
    assign is_byte    = (MemSize_in == 2'b10);
    // Size 11 falls into the word case everywhere.
    assign misaligned = (!is_half && !is_byte && (ALUResult_in[1:0] != 2'b00)) ||
                        (is_half && ALUResult_in[0]);
    assign issue      = memop & ~misaligned;

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = ReadData2_in;
        if (is_byte) begin
            be_calc    = 4'b0001 << ALUResult_in[1:0];
            wdata_calc = {4{ReadData2_in[7:0]}};
        end else if (is_half) begin
            be_calc    = ALUResult_in[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{ReadData2_in[15:0]}};
        end
    end

    assign byte_sel = Dmem_RData[{lat_addr[1:0], 3'b000} +: 8];
    assign half_sel = lat_addr[1] ? Dmem_RData[31:16] : Dmem_RData[15:0];

    always_comb begin
        load_data = Dmem_RData;
        if (lat_size == 2'b10)
            load_data = {{24{lat_signed & byte_sel[7]}}, byte_sel};
        else if (lat_size == 2'b01)
            load_data = {{16{lat_signed & half_sel[15]}}, half_sel};
    end

    always_comb begin
        if (state == IDLE)
            Stall_out = issue;
        else
            Stall_out = ~Dmem_Ready & (cnt != CNT_LAST);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            Dmem_Req      <= 1'b0;
            Dmem_We       <= 1'b0;
            Dmem_Addr     <= 32'd0;
            Dmem_WData    <= 32'd0;
            Dmem_BE       <= 4'd0;
            lat_size      <= 2'd0;
            lat_signed    <= 1'b0;
            lat_we        <= 1'b0;
            lat_regwrite  <= 1'b0;
            lat_memtoreg  <= 1'b0;
            lat_addr      <= 32'd0;
            lat_wreg      <= 5'd0;
            Valid_out     <= 1'b0;
            RegWrite_out  <= 1'b0;
            MemtoReg_out  <= 1'b0;
            ReadData_out  <= 32'd0;
            ALUResult_out <= 32'd0;
            WriteReg_out  <= 5'd0;
            AlignErr_out  <= 1'b0;
            BusErr_out    <= 1'b0;
        end else begin
            // MEM/WB defaults to a bubble; each branch overrides what it retires.
            Valid_out     <= 1'b0;
            RegWrite_out  <= 1'b0;
            MemtoReg_out  <= 1'b0;
            ReadData_out  <= 32'd0;
            ALUResult_out <= 32'd0;
            WriteReg_out  <= 5'd0;
            AlignErr_out  <= 1'b0;
            BusErr_out    <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state        <= ACCESS;
                        cnt          <= 8'd0;
                        Dmem_Req     <= 1'b1;
                        Dmem_We      <= MemWrite_in;
                        Dmem_Addr    <= {ALUResult_in[31:2], 2'b00};
                        Dmem_WData   <= wdata_calc;
                        Dmem_BE      <= be_calc;
                        lat_size     <= MemSize_in;
                        lat_signed   <= MemSigned_in;
                        lat_we       <= MemWrite_in;
                        lat_regwrite <= RegWrite_in;
                        lat_memtoreg <= MemtoReg_in;
                        lat_addr     <= ALUResult_in;
                        lat_wreg     <= WriteReg_in;
                    end else if (memop) begin
                        Valid_out     <= 1'b1;
                        AlignErr_out  <= 1'b1;
                        ALUResult_out <= ALUResult_in;
                        WriteReg_out  <= WriteReg_in;
                    end else if (Valid_in) begin
                        Valid_out     <= 1'b1;
                        RegWrite_out  <= RegWrite_in;
                        MemtoReg_out  <= MemtoReg_in;
                        ALUResult_out <= ALUResult_in;
                        WriteReg_out  <= WriteReg_in;
                    end
                end
                ACCESS: begin
                    if (Dmem_Ready) begin
                        state         <= IDLE;
                        Dmem_Req      <= 1'b0;
                        Valid_out     <= 1'b1;
                        RegWrite_out  <= lat_regwrite;
                        MemtoReg_out  <= lat_memtoreg;
                        ReadData_out  <= lat_we ? 32'd0 : load_data;
                        ALUResult_out <= lat_addr;
                        WriteReg_out  <= lat_wreg;
                    end else if (cnt == CNT_LAST) begin
                        state         <= IDLE;
                        Dmem_Req      <= 1'b0;
                        Valid_out     <= 1'b1;
                        BusErr_out    <= 1'b1;
                        ALUResult_out <= lat_addr;
                        WriteReg_out  <= lat_wreg;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a short timeout so abort and late completion are both reachable.
module tb_mem_wb_stage;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Valid_in, MemRead_in, MemWrite_in, MemSigned_in, MemtoReg_in, RegWrite_in;
    logic [1:0]  MemSize_in;
    logic [31:0] ALUResult_in, ReadData2_in;
    logic [4:0]  WriteReg_in;
    logic        Stall_out, Dmem_Req, Dmem_We;
    logic [31:0] Dmem_Addr, Dmem_WData, Dmem_RData;
    logic [3:0]  Dmem_BE;
    logic        Dmem_Ready;
    logic        Valid_out, RegWrite_out, MemtoReg_out, AlignErr_out, BusErr_out;
    logic [31:0] ReadData_out, ALUResult_out;
    logic [4:0]  WriteReg_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Valid_in(Valid_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemSize_in(MemSize_in), .MemSigned_in(MemSigned_in), .MemtoReg_in(MemtoReg_in),
        .RegWrite_in(RegWrite_in), .ALUResult_in(ALUResult_in), .ReadData2_in(ReadData2_in),
        .WriteReg_in(WriteReg_in), .Stall_out(Stall_out), .Dmem_Req(Dmem_Req),
        .Dmem_We(Dmem_We), .Dmem_Addr(Dmem_Addr), .Dmem_WData(Dmem_WData),
        .Dmem_BE(Dmem_BE), .Dmem_RData(Dmem_RData), .Dmem_Ready(Dmem_Ready),
        .Valid_out(Valid_out), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .ReadData_out(ReadData_out), .ALUResult_out(ALUResult_out),
        .WriteReg_out(WriteReg_out), .AlignErr_out(AlignErr_out), .BusErr_out(BusErr_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic m2r, input logic rw,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wreg);
        Valid_in     = v;
        MemRead_in   = rd;
        MemWrite_in  = wr;
        MemSize_in   = sz;
        MemSigned_in = sg;
        MemtoReg_in  = m2r;
        RegWrite_in  = rw;
        ALUResult_in = addr;
        ReadData2_in = wd;
        WriteReg_in  = wreg;
    endtask

    task automatic nop();
        set_op(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    endtask

    initial begin
        Rst_n      = 1'b0;
        Dmem_Ready = 1'b0;
        Dmem_RData = 32'd0;
        nop();
        tick();
        tick();
        chk("rst_valid", Valid_out, 1'b0);
        chk("rst_req", Dmem_Req, 1'b0);
        chk("rst_stall", Stall_out, 1'b0);
        chk("rst_rdata", ReadData_out, 32'd0);
        Rst_n = 1'b1;

        // lb signed from the top byte lane, ready on the first ACCESS cycle
        set_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 32'h0000_1003, 32'd0, 5'd8);
        #1;
        chk("lb_stall_idle", Stall_out, 1'b1);
        chk("lb_req_idle", Dmem_Req, 1'b0);
        tick();
        chk("lb_req", Dmem_Req, 1'b1);
        chk("lb_addr", Dmem_Addr, 32'h0000_1000);
        chk("lb_be", Dmem_BE, 4'b1000);
        chk("lb_we", Dmem_We, 1'b0);
        chk("lb_bubble", Valid_out, 1'b0);
        Dmem_Ready = 1'b1;
        Dmem_RData = 32'h80AA_BBCC;
        #1;
        chk("lb_stall_rdy", Stall_out, 1'b0);
        tick();
        nop();
        Dmem_Ready = 1'b0;
        chk("lb_valid", Valid_out, 1'b1);
        chk("lb_data", ReadData_out, 32'hFFFF_FF80);
        chk("lb_wreg", WriteReg_out, 5'd8);
        chk("lb_regwrite", RegWrite_out, 1'b1);
        chk("lb_req_done", Dmem_Req, 1'b0);

        // sh to upper half, three wait cycles; ready lands on the last counter value
        set_op(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 5'd0);
        #1;
        chk("sh_stall_idle", Stall_out, 1'b1);
        tick();
        chk("sh_be", Dmem_BE, 4'b1100);
        chk("sh_wdata", Dmem_WData, 32'hABCD_ABCD);
        chk("sh_we", Dmem_We, 1'b1);
        for (int w = 0; w < 3; w++) begin
            chk("sh_stall_wait", Stall_out, 1'b1);
            chk("sh_bubble", Valid_out, 1'b0);
            tick();
        end
        chk("sh_bubble4", Valid_out, 1'b0);
        chk("sh_req_held", Dmem_Req, 1'b1);
        Dmem_Ready = 1'b1;
        #1;
        chk("sh_stall_rdy", Stall_out, 1'b0);
        tick();
        nop();
        Dmem_Ready = 1'b0;
        chk("sh_valid", Valid_out, 1'b1);
        chk("sh_regwrite", RegWrite_out, 1'b0);
        chk("sh_rdata_zero", ReadData_out, 32'd0);
        chk("sh_buserr", BusErr_out, 1'b0);

        // misaligned lw: no request, one-cycle AlignErr
        set_op(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'h0000_0006, 32'd0, 5'd9);
        #1;
        chk("mis_stall", Stall_out, 1'b0);
        tick();
        nop();
        chk("mis_req", Dmem_Req, 1'b0);
        chk("mis_valid", Valid_out, 1'b1);
        chk("mis_alignerr", AlignErr_out, 1'b1);
        chk("mis_regwrite", RegWrite_out, 1'b0);
        chk("mis_rdata", ReadData_out, 32'd0);
        tick();
        chk("mis_pulse_end", AlignErr_out, 1'b0);
        chk("mis_valid_end", Valid_out, 1'b0);

        // lw that never gets Ready: abort after 4 request cycles
        set_op(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'd0, 5'd10);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_req", Dmem_Req, 1'b1);
            chk("to_stall", Stall_out, (i < 3) ? 1'b1 : 1'b0);
            tick();
        end
        nop();
        chk("to_req_drop", Dmem_Req, 1'b0);
        chk("to_valid", Valid_out, 1'b1);
        chk("to_buserr", BusErr_out, 1'b1);
        chk("to_regwrite", RegWrite_out, 1'b0);

        // add then lhu back to back
        set_op(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 32'd7, 32'd0, 5'd3);
        #1;
        chk("add_stall", Stall_out, 1'b0);
        tick();
        chk("to_pulse_end", BusErr_out, 1'b0);
        chk("add_valid", Valid_out, 1'b1);
        chk("add_alu", ALUResult_out, 32'd7);
        chk("add_regwrite", RegWrite_out, 1'b1);
        set_op(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'd0, 5'd4);
        #1;
        chk("lhu_stall", Stall_out, 1'b1);
        tick();
        chk("lhu_bubble", Valid_out, 1'b0);
        chk("lhu_be", Dmem_BE, 4'b0011);
        Dmem_Ready = 1'b1;
        Dmem_RData = 32'h0000_F00D;
        tick();
        nop();
        Dmem_Ready = 1'b0;
        chk("lhu_valid", Valid_out, 1'b1);
        chk("lhu_data", ReadData_out, 32'h0000_F00D);
        chk("lhu_wreg", WriteReg_out, 5'd4);
        tick();
        chk("lhu_no_dup", Valid_out, 1'b0);

        // sb to lane 1, then lh signed from lower half
        set_op(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0077, 5'd0);
        tick();
        chk("sb_be", Dmem_BE, 4'b0010);
        chk("sb_wdata", Dmem_WData, 32'h7777_7777);
        Dmem_Ready = 1'b1;
        tick();
        Dmem_Ready = 1'b0;
        set_op(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'd0, 5'd5);
        chk("sb_valid", Valid_out, 1'b1);
        tick();
        Dmem_Ready = 1'b1;
        Dmem_RData = 32'h1234_8001;
        tick();
        nop();
        Dmem_Ready = 1'b0;
        chk("lh_data", ReadData_out, 32'hFFFF_8001);

        // reset in the middle of an access
        set_op(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 32'd0, 5'd6);
        tick();
        chk("ra_req", Dmem_Req, 1'b1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("ra_req_async", Dmem_Req, 1'b0);
        nop();
        tick();
        Rst_n = 1'b1;
        Dmem_Ready = 1'b1;
        Dmem_RData = 32'hDEAD_BEEF;
        chk("ra_valid_rst", Valid_out, 1'b0);
        tick();
        Dmem_Ready = 1'b0;
        chk("ra_late_valid", Valid_out, 1'b0);
        chk("ra_late_rdata", ReadData_out, 32'd0);
        chk("ra_late_req", Dmem_Req, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access stage plus MEM/WB pipeline register for the 5-stage MIPS core. It consumes the EX/MEM register outputs and performs loads and stores (word, halfword, byte) over a variable-latency data-memory handshake. It stalls upstream while an access is outstanding and registers writeback data for the WB stage. It also flags misaligned accesses and memory timeouts.

Parameters:
TIMEOUT_CYCLES, 255, max ACCESS cycles without Dmem_Ready before abort (1..255)

Ports:
Clk  in  1  rising-edge clock
Rst_n  in  1  asynchronous active-low reset
Valid_in  in  1  EX/MEM slot holds a real instruction
MemRead_in  in  1  load
MemWrite_in  in  1  store
MemSize_in  in  2  00 word, 01 half, 10 byte (11 treated as word)
MemSigned_in  in  1  sign-extend sub-word loads
MemtoReg_in  in  1  WB selects memory data
RegWrite_in  in  1  WB writes register file
ALUResult_in  in  32  effective address / ALU result
ReadData2_in  in  32  store data
WriteReg_in  in  5  destination register
Stall_out  out  1  hold EX/MEM and earlier stages this cycle (combinational)
Dmem_Req  out  1  memory request (registered)
Dmem_We  out  1  1 = write
Dmem_Addr  out  32  word address, bits[1:0] = 0
Dmem_WData  out  32  lane-replicated store data
Dmem_BE  out  4  byte enables, bit0 = bits[7:0]
Dmem_RData  in  32  read data, valid when Dmem_Ready
Dmem_Ready  in  1  transfer completes at this rising edge
Valid_out, RegWrite_out, MemtoReg_out  out  1 each  MEM/WB controls
ReadData_out  out  32  aligned/extended load data, 0 for non-loads
ALUResult_out  out  32  registered ALUResult_in
WriteReg_out  out  5  registered destination
AlignErr_out, BusErr_out  out  1 each  one-cycle error pulses, aligned with Valid_out

Behaviour:
- Reset (async): state IDLE; every registered output 0; timeout counter 0. Reset during ACCESS drops Dmem_Req immediately, and the pending response is ignored.
- memop = Valid_in & (MemRead_in | MemWrite_in). If both read and write are set, the access is a write.
- Misaligned: word with addr[1:0]≠0, or half with addr[0]≠0. No access is issued. Next edge loads MEM/WB with Valid_out=1, RegWrite_out=0, AlignErr_out=1, ReadData_out=0. No stall.
- FSM IDLE:
  - Non-memop or invalid: single-cycle pass-through into MEM/WB; Valid_out=Valid_in.
  - Aligned memop: Stall_out=1. Next edge: ACCESS, Dmem_Req=1, request fields latched, counter=0, MEM/WB loaded with a bubble.
- FSM ACCESS: request fields stay stable while Req is high.
  - Stall_out = ~Dmem_Ready & (counter ≠ TIMEOUT_CYCLES-1).
  - Edge with Dmem_Ready=1: Req=0, return to IDLE, load MEM/WB with the result.
  - Edge without Dmem_Ready: counter+1, MEM/WB gets a bubble.
  - Counter reaching TIMEOUT_CYCLES-1 without Dmem_Ready: abort. Req=0, go to IDLE, MEM/WB gets Valid_out=1, RegWrite_out=0, BusErr_out=1.
- Minimum memop latency: 2 cycles (IDLE + ACCESS with Ready). A bubble is any Valid_out=0 with all controls 0.
- Little-endian lanes:
  - Byte: BE=1<<addr[1:0]; WData = byte replicated ×4.
  - Half: BE=0011 when addr[1]=0, 1100 when addr[1]=1; WData = half replicated ×2.
  - Word: BE=1111.
- Load data: select the lane from addr. Sign-extend when MemSigned_in=1, else zero-extend. Word passes through unchanged.
- Store completion: ReadData_out=0; RegWrite_out passes RegWrite_in.
- Dmem_Ready while IDLE is ignored.

Test Plan:
- Reset asserted mid-ACCESS → Dmem_Req drops without waiting for a clock edge. After release: outputs 0, state IDLE, and a late Dmem_Ready produces no Valid_out.
- lb, addr 0x1003, MemSigned=1, RData 0x80AABBCC, Ready on first ACCESS cycle → Stall high for exactly 1 cycle, Dmem_Addr 0x1000, ReadData_out 0xFFFFFF80, Valid_out 2 cycles after issue.
- sh, addr 0x2002, data 0x1234ABCD, Ready after 3 wait cycles → BE 1100, WData 0xABCDABCD, Stall 4 cycles, 4 bubbles, then Valid_out=1 with RegWrite_out=0.
- lw at 0x0006 → no Dmem_Req; next cycle AlignErr_out=1, RegWrite_out=0, Stall never asserted.
- TIMEOUT_CYCLES=4, lw with Ready never asserted → Req high 4 cycles, then drops; BusErr_out=1 for one cycle; next instruction proceeds.
- Back-to-back: add (RegWrite, ALUResult 7), lhu at 0x10 with RData 0x0000F00D, Ready immediate → add retires at cycle 1, lhu retires at cycle 3 with 0x0000F00D, no lost or duplicated Valid_out.
